transfer_layer_tx: RTL

Egress half of the transaction-layer transfer block: merges four 12-bit per-class input ports (P0–P3) into a single output FIFO toward the link. It sits opposite the ingress router that splits one input stream into four port FIFOs. Transfers are arbitrated between ports and gated by high/low occupancy thresholds on the output FIFO. Per-port transfer counters are readable through a `req`/`idx` handshake.

---
 rtl/transfer_layer_tx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/transfer_layer_tx.sv
// Egress merge: four 12-bit port FIFOs arbitrated into one output FIFO toward the link.
// Latency: push to earliest transfer 1 edge, pop to dataOut 1 edge; 1 word/cycle sustained.
// Backpressure: full port drops the push (sticky errorOut); transfers pause on output occupancy thresholds.
// Optional TLTX_RR_EN: round-robin arbitration instead of fixed priority P0 > P1 > P2 > P3.
module transfer_layer_tx #(
    parameter int DATA_W  = 12,
    parameter int PORT_AW = 2,
    parameter int OUT_AW  = 3,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [2:0]        Umbral_bajo,
    input  logic [2:0]        Umbral_alto,
    input  logic              pushInP0,
    input  logic              pushInP1,
    input  logic              pushInP2,
    input  logic              pushInP3,
    input  logic [DATA_W-1:0] dataInP0,
    input  logic [DATA_W-1:0] dataInP1,
    input  logic [DATA_W-1:0] dataInP2,
    input  logic [DATA_W-1:0] dataInP3,
    output logic [3:0]        fullInP,
    input  logic              popOut,
    output logic [DATA_W-1:0] dataOut,
    output logic              emptyOut,
    output logic [3:0]        errorOut,
    input  logic              req,
    input  logic [1:0]        idx,
    output logic [CNT_W-1:0]  counterOut,
    output logic              counterValid,
    output logic [1:0]        state
);
    localparam int PORT_DEPTH = 1 << PORT_AW;
    localparam int OUT_DEPTH  = 1 << OUT_AW;
    localparam logic [PORT_AW:0] PORT_FULL = {1'b1, {PORT_AW{1'b0}}};
    localparam logic [OUT_AW:0]  OUT_FULL  = {1'b1, {OUT_AW{1'b0}}};

    typedef enum logic [1:0] {ST_RESET = 2'd0, ST_INIT = 2'd1, ST_IDLE = 2'd2, ST_ACTIVE = 2'd3} state_t;

    state_t state_q, state_d;
    logic [2:0] alto_q, alto_d, bajo_q, bajo_d;
    logic [3:0][PORT_DEPTH-1:0][DATA_W-1:0] pmem_q, pmem_d;
    logic [3:0][PORT_AW-1:0] pwr_q, pwr_d, prd_q, prd_d;
    logic [3:0][PORT_AW:0]   pcnt_q, pcnt_d;
    logic [OUT_DEPTH-1:0][DATA_W-1:0] omem_q, omem_d;
    logic [OUT_AW-1:0] owr_q, owr_d, ord_q, ord_d;
    logic [OUT_AW:0]   ocnt_q, ocnt_d;
    logic              pause_q, pause_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [3:0]        err_q, err_d;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  cout_q, cout_d;
    logic              cvld_q, cvld_d;
    logic [1:0]        rr_q, rr_d;

    logic [3:0]             push_vec, nonempty;
    logic [3:0][DATA_W-1:0] din;
    logic                   gnt_vld, xfer, pop_ok, push_ok, pop_port;
    logic [1:0]             gnt_idx, cand;

    assign push_vec = {pushInP3, pushInP2, pushInP1, pushInP0};
    assign din      = {dataInP3, dataInP2, dataInP1, dataInP0};

    // Port non-empty flags feed both the arbiter and the FSM
    always_comb begin
        nonempty = '0;
        for (int i = 0; i < 4; i++) nonempty[i] = (pcnt_q[i] != '0);
    end

`ifdef TLTX_RR_EN
    // Round-robin: search begins at the port after the last granted one
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_q + 2'(k);
            if (!gnt_vld && nonempty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end
`else
    // Fixed priority: lowest-numbered non-empty port wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (nonempty[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = 2'(k);
            end
        end
    end
`endif

    assign xfer   = (state_q == ST_ACTIVE) && !pause_q && (ocnt_q != OUT_FULL) && gnt_vld;
    assign pop_ok = popOut && (ocnt_q != '0);

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE:   if (init) state_d = ST_INIT;
                       else if (|nonempty) state_d = ST_ACTIVE;
            ST_ACTIVE: if (init) state_d = ST_INIT;
                       else if (!(|nonempty)) state_d = ST_IDLE;
            default:   state_d = ST_RESET;
        endcase
    end

    // Datapath: port FIFOs, output FIFO, pause hysteresis, counters and counter read
    always_comb begin
        alto_d = alto_q;  bajo_d = bajo_q;
        pmem_d = pmem_q;  pwr_d = pwr_q;  prd_d = prd_q;  pcnt_d = pcnt_q;
        omem_d = omem_q;  owr_d = owr_q;  ord_d = ord_q;
        dout_d = dout_q;  err_d = err_q;  cnt_d = cnt_q;
        cout_d = cout_q;  rr_d = rr_q;
        push_ok = 1'b0;   pop_port = 1'b0;

        if (state_q == ST_INIT && init) begin
            alto_d = Umbral_alto;
            bajo_d = Umbral_bajo;
        end

        for (int i = 0; i < 4; i++) begin
            push_ok  = push_vec[i] && (pcnt_q[i] != PORT_FULL);
            pop_port = xfer && (gnt_idx == 2'(i));
            if (push_ok) begin
                pmem_d[i][pwr_q[i]] = din[i];
                pwr_d[i] = pwr_q[i] + PORT_AW'(1);
            end else if (push_vec[i]) begin
                err_d[i] = 1'b1;
            end
            if (pop_port) begin
                prd_d[i] = prd_q[i] + PORT_AW'(1);
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            pcnt_d[i] = pcnt_q[i] + (PORT_AW+1)'(push_ok) - (PORT_AW+1)'(pop_port);
        end

        if (xfer) begin
            omem_d[owr_q] = pmem_q[gnt_idx][prd_q[gnt_idx]];
            owr_d = owr_q + OUT_AW'(1);
            rr_d  = gnt_idx;
        end
        if (pop_ok) begin
            dout_d = omem_q[ord_q];
            ord_d  = ord_q + OUT_AW'(1);
        end
        ocnt_d = ocnt_q + (OUT_AW+1)'(xfer) - (OUT_AW+1)'(pop_ok);

        // Pause decision uses post-edge occupancy so the flag reflects the new fill level
        pause_d = pause_q;
        if (alto_q == 3'd0)                  pause_d = 1'b0;
        else if (ocnt_d >= {1'b0, alto_q})   pause_d = 1'b1;
        else if (ocnt_d <= {1'b0, bajo_q})   pause_d = 1'b0;

        // Counter snapshot is taken before this edge's increment
        cvld_d = req;
        if (req) cout_d = cnt_q[idx];
    end

    // Control and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
            alto_q  <= '0;  bajo_q <= '0;
            pwr_q   <= '0;  prd_q  <= '0;  pcnt_q <= '0;
            owr_q   <= '0;  ord_q  <= '0;  ocnt_q <= '0;
            pause_q <= 1'b0;
            dout_q  <= '0;  err_q  <= '0;  cnt_q  <= '0;
            cout_q  <= '0;  cvld_q <= 1'b0;
            rr_q    <= 2'd3;
        end else begin
            state_q <= state_d;
            alto_q  <= alto_d;  bajo_q <= bajo_d;
            pwr_q   <= pwr_d;   prd_q  <= prd_d;  pcnt_q <= pcnt_d;
            owr_q   <= owr_d;   ord_q  <= ord_d;  ocnt_q <= ocnt_d;
            pause_q <= pause_d;
            dout_q  <= dout_d;  err_q  <= err_d;  cnt_q  <= cnt_d;
            cout_q  <= cout_d;  cvld_q <= cvld_d;
            rr_q    <= rr_d;
        end
    end

    // Storage arrays need no reset; pointers define validity
    always_ff @(posedge clk) begin
        pmem_q <= pmem_d;
        omem_q <= omem_d;
    end

    always_comb begin
        fullInP = '0;
        for (int i = 0; i < 4; i++) fullInP[i] = (pcnt_q[i] == PORT_FULL);
    end

    assign emptyOut     = (ocnt_q == '0);
    assign dataOut      = dout_q;
    assign errorOut     = err_q;
    assign counterOut   = cout_q;
    assign counterValid = cvld_q;
    assign state        = state_q;
endmodule
